// File: rtl/regfile_sb.sv
// regfile_sb: 32 x 32-bit GPR file with a load-use scoreboard and HI/LO registers.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   we, waddr, wdata            write-back port (from MEM/WB)
//   re1/re2, raddr1/raddr2      read-port enables and addresses
//   rdata1/rdata2               combinational read data with write-back bypass
//   ld_issue, ld_addr           a load entering EX claims its destination register
//   busy_stall                  a read hits a register owned by an in-flight load
//   hilo_we, hi_i, lo_i         HI/LO write
//   hi_o, lo_o                  HI/LO read with same-cycle bypass
module regfile_sb (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re1,
    input  logic        re2,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        ld_issue,
    input  logic [4:0]  ld_addr,
    output logic        busy_stall,
    input  logic        hilo_we,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] gpr_q [32];
    logic [31:0] gpr_d [32];
    logic [31:0] busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic hit1, hit2;

    // Next-state for all storage. The stall output never gates any of this.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        busy_d = busy_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr_d[i] = '0;
            end
            busy_d = '0;
            hi_d   = '0;
            lo_d   = '0;
        end else begin
            if (we && (waddr != 5'd0)) begin
                gpr_d[waddr] = wdata;
            end
            // Clear before set so a load issuing to the same register wins.
            if (we) begin
                busy_d[waddr] = 1'b0;
            end
            if (ld_issue && (ld_addr != 5'd0)) begin
                busy_d[ld_addr] = 1'b1;
            end
            if (hilo_we) begin
                hi_d = hi_i;
                lo_d = lo_i;
            end
        end

        gpr_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            gpr_q[i] <= gpr_d[i];
        end
        busy_q <= busy_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
    end

    // Read port 1
    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != 5'd0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = gpr_q[raddr1];
            end
        end
    end

    // Read port 2
    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != 5'd0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = gpr_q[raddr2];
            end
        end
    end

    // A write-back landing this cycle resolves the hazard via the bypass.
    always_comb begin
        hit1 = re1 && (raddr1 != 5'd0) && busy_q[raddr1] && !(we && (waddr == raddr1));
        hit2 = re2 && (raddr2 != 5'd0) && busy_q[raddr2] && !(we && (waddr == raddr2));
        busy_stall = !rst && (hit1 || hit2);
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = hilo_we ? hi_i : hi_q;
            lo_o = hilo_we ? lo_i : lo_q;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ld_issue;
    logic [4:0]  ld_addr;
    logic        busy_stall;
    logic        hilo_we;
    logic [31:0] hi_i, lo_i;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .re1        (re1),
        .re2        (re2),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .ld_issue   (ld_issue),
        .ld_addr    (ld_addr),
        .busy_stall (busy_stall),
        .hilo_we    (hilo_we),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and return all inputs to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst = 0; we = 0; waddr = 0; wdata = 0; re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
        ld_issue = 0; ld_addr = 0; hilo_we = 0; hi_i = 0; lo_i = 0;
    endtask

    initial begin
        rst = 1; we = 0; waddr = 0; wdata = 0; re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
        ld_issue = 0; ld_addr = 0; hilo_we = 0; hi_i = 0; lo_i = 0;
        @(posedge clk);
        #1;

        // Reset cycle: outputs forced to 0, writes/loads/hilo ignored.
        rst = 1; we = 1; waddr = 5; wdata = 32'h1111_1111;
        hilo_we = 1; hi_i = 32'h7; lo_i = 32'h8;
        ld_issue = 1; ld_addr = 6; re1 = 1; raddr1 = 5;
        #1;
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_hi_o", hi_o, 32'h0);
        chk("rst_stall", {31'b0, busy_stall}, 32'h0);
        next_cycle();

        // After reset everything reads clear.
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 6;
        #1;
        chk("post_rst_r5", rdata1, 32'h0);
        chk("post_rst_stall_r6", {31'b0, busy_stall}, 32'h0);
        chk("post_rst_hi", hi_o, 32'h0);
        chk("post_rst_lo", lo_o, 32'h0);
        next_cycle();

        // Write r5; read disabled port gives 0.
        we = 1; waddr = 5; wdata = 32'hDEAD_BEEF; raddr1 = 5;
        #1;
        chk("re1_off", rdata1, 32'h0);
        next_cycle();

        // r5 readable; write to r0 discarded and not bypassed.
        we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 0;
        #1;
        chk("r5_read", rdata1, 32'hDEAD_BEEF);
        chk("r0_no_bypass", rdata2, 32'h0);
        next_cycle();

        re1 = 1; raddr1 = 0; re2 = 1; raddr2 = 5;
        #1;
        chk("r0_read", rdata1, 32'h0);
        chk("r5_port2", rdata2, 32'hDEAD_BEEF);
        next_cycle();

        // Same-cycle bypass on port 2.
        we = 1; waddr = 7; wdata = 32'h1234_5678; re2 = 1; raddr2 = 7; raddr1 = 7;
        #1;
        chk("bypass_r7", rdata2, 32'h1234_5678);
        chk("bypass_re1_off", rdata1, 32'h0);
        next_cycle();

        // r7 stored; issue load to r9.
        re2 = 1; raddr2 = 7; ld_issue = 1; ld_addr = 9; re1 = 1; raddr1 = 9;
        #1;
        chk("r7_stored", rdata2, 32'h1234_5678);
        chk("ld9_not_yet_busy", {31'b0, busy_stall}, 32'h0);
        next_cycle();

        re1 = 1; raddr1 = 9;
        #1;
        chk("ld9_stall", {31'b0, busy_stall}, 32'h1);
        chk("ld9_old_data", rdata1, 32'h0);
        next_cycle();

        // Write-back of the load resolves the stall in the same cycle.
        re1 = 1; raddr1 = 9; we = 1; waddr = 9; wdata = 32'hCAFE_F00D;
        #1;
        chk("ld9_wb_stall", {31'b0, busy_stall}, 32'h0);
        chk("ld9_wb_bypass", rdata1, 32'hCAFE_F00D);
        next_cycle();

        re1 = 1; raddr1 = 9;
        #1;
        chk("ld9_cleared", {31'b0, busy_stall}, 32'h0);
        chk("r9_stored", rdata1, 32'hCAFE_F00D);
        next_cycle();

        // Load and write-back to r3 on the same edge: set wins.
        ld_issue = 1; ld_addr = 3; we = 1; waddr = 3; wdata = 32'h33;
        next_cycle();

        re2 = 1; raddr2 = 3;
        #1;
        chk("r3_set_prio_stall", {31'b0, busy_stall}, 32'h1);
        chk("r3_written", rdata2, 32'h33);
        next_cycle();

        // Disabled read never stalls; load to r0 sets nothing.
        raddr2 = 3; ld_issue = 1; ld_addr = 0;
        #1;
        chk("r3_re_off_stall", {31'b0, busy_stall}, 32'h0);
        next_cycle();

        // HI/LO bypass and write.
        re1 = 1; raddr1 = 0; hilo_we = 1; hi_i = 32'hA; lo_i = 32'hB;
        #1;
        chk("r0_never_busy", {31'b0, busy_stall}, 32'h0);
        chk("hi_bypass", hi_o, 32'hA);
        chk("lo_bypass", lo_o, 32'hB);
        next_cycle();

        hi_i = 32'hFFFF; lo_i = 32'hEEEE;
        #1;
        chk("hi_held", hi_o, 32'hA);
        chk("lo_held", lo_o, 32'hB);
        next_cycle();

        // r4 = 0x55 with busy[4] set.
        ld_issue = 1; ld_addr = 4; we = 1; waddr = 4; wdata = 32'h55;
        next_cycle();

        re1 = 1; raddr1 = 4;
        #1;
        chk("r4_busy_stall", {31'b0, busy_stall}, 32'h1);
        chk("r4_data", rdata1, 32'h55);
        next_cycle();

        // Reset pulse mid-load.
        rst = 1; re1 = 1; raddr1 = 4;
        #1;
        chk("rst2_rdata1", rdata1, 32'h0);
        chk("rst2_stall", {31'b0, busy_stall}, 32'h0);
        chk("rst2_hi", hi_o, 32'h0);
        next_cycle();

        re1 = 1; raddr1 = 4;
        #1;
        chk("r4_cleared", rdata1, 32'h0);
        chk("r4_busy_cleared", {31'b0, busy_stall}, 32'h0);
        chk("hi_cleared", hi_o, 32'h0);
        chk("lo_cleared", lo_o, 32'h0);
        re1 = 0; re2 = 1; raddr2 = 3;
        #1;
        chk("r3_busy_cleared", {31'b0, busy_stall}, 32'h0);
        chk("r3_cleared", rdata2, 32'h0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
